// File: rtl/pipe_delay.sv
// Elastic valid/ready delay line of CNT register stages with bubble collapse, flush and occupancy.
// Optional feature: define PIPE_DELAY_SKID_EN to add a 2-entry skid buffer at the output.
module pipe_delay #(
  parameter int WIDTH = 32,
  parameter int CNT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       occ
);

  generate
    if (CNT < 0 || CNT > 8) begin : g_bad_cnt
      $error("pipe_delay: CNT must be in 0..8");
    end
  endgenerate

  // Tail of the stage chain, as seen by the output (or by the skid buffer).
  logic             sink_ready;
  logic             line_valid;
  logic [WIDTH-1:0] line_data;
  logic [3:0]       line_occ;

  generate
    if (CNT == 0) begin : g_wire
      assign line_valid = in_valid;
      assign line_data  = in_data;
      assign line_occ   = '0;
`ifdef PIPE_DELAY_SKID_EN
      assign in_ready   = sink_ready & ~flush;
`else
      assign in_ready   = sink_ready;
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, rst, flush};
`endif
    end else begin : g_stages
      logic [CNT-1:0]   v_q, v_d, adv, vchain;
      logic [WIDTH-1:0] d_q [CNT];
      logic [WIDTH-1:0] d_d [CNT];
      logic [WIDTH-1:0] dchain [CNT];
      logic             take;

      // Ripple from the output back: a stage may load if it is empty or its successor moves.
      always_comb begin
        logic a;
        a   = sink_ready;
        adv = '0;
        for (int unsigned k = 0; k < CNT; k++) begin
          a = ~v_q[CNT-1-k] | a;
          adv[CNT-1-k] = a;
        end
      end

      assign in_ready = adv[0] & ~flush;
      assign take     = in_valid & in_ready;

      always_comb begin
        vchain[0] = take;
        dchain[0] = in_data;
        for (int unsigned i = 1; i < CNT; i++) begin
          vchain[i] = v_q[i-1];
          dchain[i] = d_q[i-1];
        end
        v_d = v_q;
        d_d = d_q;
        for (int unsigned i = 0; i < CNT; i++) begin
          if (adv[i]) begin
            v_d[i] = vchain[i];
            if (vchain[i]) d_d[i] = dchain[i];
          end
        end
        if (flush) v_d = '0;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
          d_q <= '{default: '0};
        end else begin
          v_q <= v_d;
          d_q <= d_d;
        end
      end

      always_comb begin
        line_occ = '0;
        for (int unsigned i = 0; i < CNT; i++) line_occ = line_occ + 4'(v_q[i]);
      end

      assign line_valid = v_q[CNT-1];
      assign line_data  = d_q[CNT-1];
    end
  endgenerate

`ifdef PIPE_DELAY_SKID_EN
  logic [1:0]       sk_cnt_q, sk_cnt_d;
  logic [WIDTH-1:0] sk0_q, sk0_d, sk1_q, sk1_d;
  logic             line_push, sk_pop;

  // Ready depends only on skid occupancy, which breaks the out_ready->in_ready path.
  assign sink_ready = ~sk_cnt_q[1];
  assign line_push  = line_valid & sink_ready & ~flush;
  assign out_valid  = (sk_cnt_q != 2'd0);
  assign out_data   = sk0_q;
  assign sk_pop     = out_valid & out_ready;
  assign occ        = line_occ + {2'b00, sk_cnt_q};

  always_comb begin
    sk_cnt_d = sk_cnt_q;
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    case ({line_push, sk_pop})
      2'b10: begin
        if (sk_cnt_q == 2'd0) sk0_d = line_data;
        else                  sk1_d = line_data;
        sk_cnt_d = sk_cnt_q + 2'd1;
      end
      2'b01: begin
        sk0_d    = sk1_q;
        sk_cnt_d = sk_cnt_q - 2'd1;
      end
      2'b11: sk0_d = line_data;
      default: ;
    endcase
    if (flush) sk_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sk_cnt_q <= '0;
      sk0_q    <= '0;
      sk1_q    <= '0;
    end else begin
      sk_cnt_q <= sk_cnt_d;
      sk0_q    <= sk0_d;
      sk1_q    <= sk1_d;
    end
  end
`else
  assign sink_ready = out_ready;
  assign out_valid  = line_valid;
  assign out_data   = line_data;
  assign occ        = line_occ;
`endif

endmodule

// File: tb/tb_pipe_delay.sv
// Self-checking bench for pipe_delay: queue reference model with random traffic,
// hand-written corner sequences on CNT=3, and a vector table for CNT=0.
module tb_pipe_delay;

  localparam int CA = 3;
`ifdef PIPE_DELAY_SKID_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif
  localparam int LAT = CA + SK;
  localparam int CAP = CA + 2 * SK;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_id, a_od;
  logic [3:0]  a_occ;

  logic        b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
  logic [7:0]  b_id, b_od;
  logic [3:0]  b_occ;

  pipe_delay #(.WIDTH(32), .CNT(CA)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occ(a_occ)
  );

  pipe_delay #(.WIDTH(8), .CNT(0)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occ(b_occ)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    int          c;
  } ent_t;
  ent_t q[$];
  int   cyc_n = 0;
  bit   exact_lat = 0;

  logic        s_ir, s_ov;
  logic [31:0] s_od;
  logic [3:0]  s_occ;

  // One clock cycle on u_a: drive, sample before the edge, update the queue model, advance.
  task automatic cyc(input logic vi, input logic [31:0] di, input logic ordy, input logic fl);
    ent_t e;
    logic ir_alt;
    a_iv = vi; a_id = di; a_flush = fl;
`ifdef PIPE_DELAY_SKID_EN
    a_or = ~ordy; #1; ir_alt = a_ir;
`endif
    a_or = ordy; #1;
    s_ir = a_ir; s_ov = a_ov; s_od = a_od; s_occ = a_occ;
`ifdef PIPE_DELAY_SKID_EN
    chk("in_ready_indep_of_out_ready", s_ir, ir_alt);
`endif
    chk("occ_vs_model", s_occ, q.size());
    chk("occ_bound", s_occ <= CAP, 1);
    if (s_ov) chk("out_data_order", s_od, (q.size() > 0) ? q[0].d : 'x);
    if (s_ov && ordy && q.size() > 0) begin
      e = q.pop_front();
      if (exact_lat) chk("latency_exact", cyc_n - e.c, LAT);
      else           chk("latency_min", (cyc_n - e.c) >= LAT, 1);
    end
    if (fl) q.delete();
    if (vi && s_ir) q.push_back('{d: di, c: cyc_n});
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic do_reset(input logic vi, input logic ordy);
    a_rst = 1'b1; a_iv = vi; a_id = 32'hDEAD_BEEF; a_or = ordy; a_flush = 1'b0;
    @(posedge clk); #1;
    cyc_n++;
    a_rst = 1'b0;
    q.delete();
  endtask

  task automatic drain();
    repeat (LAT + CAP + 2) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", q.size(), 0);
  endtask

  typedef struct {
    logic       rst, fl, vi, ordy;
    logic [7:0] d;
    logic       eov, eir;
    logic [7:0] eod;
    logic [3:0] eocc;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int n;
    logic vi, ordy, fl;
    logic [31:0] d;

    tbl[0] = '{rst: 0, fl: 0, vi: 1, ordy: 1, d: 8'h5A, eov: 1, eir: 1, eod: 8'h5A, eocc: 0};
    tbl[1] = '{rst: 0, fl: 0, vi: 1, ordy: 0, d: 8'hC3, eov: 1, eir: 0, eod: 8'hC3, eocc: 0};
    tbl[2] = '{rst: 0, fl: 0, vi: 0, ordy: 1, d: 8'h3C, eov: 0, eir: 1, eod: 8'h3C, eocc: 0};
    tbl[3] = '{rst: 0, fl: 1, vi: 1, ordy: 1, d: 8'h81, eov: 1, eir: 1, eod: 8'h81, eocc: 0};
    tbl[4] = '{rst: 1, fl: 0, vi: 1, ordy: 1, d: 8'h7E, eov: 1, eir: 1, eod: 8'h7E, eocc: 0};
    tbl[5] = '{rst: 1, fl: 1, vi: 0, ordy: 0, d: 8'h00, eov: 0, eir: 0, eod: 8'h00, eocc: 0};

    b_rst = 0; b_flush = 0; b_iv = 0; b_or = 0; b_id = '0;
    a_rst = 1; a_flush = 0; a_iv = 0; a_or = 0; a_id = '0;
    repeat (2) @(posedge clk);
    #1;

    // CNT=0 is a pure wire path; rst and flush must not matter.
`ifndef PIPE_DELAY_SKID_EN
    for (int i = 0; i < 6; i++) begin
      b_rst = tbl[i].rst; b_flush = tbl[i].fl; b_iv = tbl[i].vi;
      b_or = tbl[i].ordy; b_id = tbl[i].d;
      #1;
      chk($sformatf("cnt0_out_valid[%0d]", i), b_ov, tbl[i].eov);
      chk($sformatf("cnt0_out_data[%0d]", i), b_od, tbl[i].eod);
      chk($sformatf("cnt0_in_ready[%0d]", i), b_ir, tbl[i].eir);
      chk($sformatf("cnt0_occ[%0d]", i), b_occ, tbl[i].eocc);
    end
    b_rst = 0; b_flush = 0;
`endif

    // Reset state.
    do_reset(1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("reset_out_valid", s_ov, 0);
    chk("reset_out_data", s_od, 0);
    chk("reset_occ", s_occ, 0);
    chk("reset_in_ready", s_ir, 1);

    // Back-to-back stream with out_ready held high.
    exact_lat = 1;
    for (int i = 0; i < 16 + LAT; i++) begin
      cyc(i < 16, 32'(i + 1), 1'b1, 1'b0);
      if (i < 16) chk("stream_in_ready", s_ir, 1);
      if (i >= LAT && i < 16) begin
        chk("stream_occ_steady", s_occ, LAT);
        chk("stream_no_gap", s_ov, 1);
      end
    end
    drain();
    exact_lat = 0;

    // Fill to capacity with out_ready low, then release.
    do_reset(1'b0, 1'b0);
    for (int k = 0; k < CAP; k++) cyc(1'b1, 32'hA + 32'(k), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("full_occ", s_occ, CAP);
    chk("full_in_ready", s_ir, 0);
    cyc(1'b1, 32'hF, 1'b1, 1'b0);
    chk("release_in_ready", s_ir, (SK == 0) ? 1 : 0);
    chk("release_head", s_od, 32'hA);
    drain();

    // Gapped arrivals while stalled: bubbles collapse, ready drops only when full.
    do_reset(1'b0, 1'b0);
    for (int k = 0; k <= CAP; k++) begin
      cyc(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0);
      chk($sformatf("bubble_in_ready[%0d]", k), s_ir, (k < CAP) ? 1 : 0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
    end
    chk("bubble_full_occ", s_occ, CAP);
    drain();

    // Flush a full line with input offered.
    do_reset(1'b0, 1'b0);
    for (int k = 0; k < CAP; k++) cyc(1'b1, 32'h11 * 32'(k + 1), 1'b0, 1'b0);
    cyc(1'b1, 32'h99, 1'b0, 1'b1);
    chk("flush_in_ready", s_ir, 0);
    cyc(1'b1, 32'h77, 1'b1, 1'b0);
    chk("flush_occ_after", s_occ, 0);
    chk("flush_out_valid_after", s_ov, 0);
    chk("flush_in_ready_after", s_ir, 1);
    drain();

    // Reset in the middle of a stream, then restart.
    exact_lat = 1;
    for (int k = 0; k < 2; k++) cyc(1'b1, 32'h101 + 32'(k), 1'b1, 1'b0);
    do_reset(1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("midrst_out_valid", s_ov, 0);
    chk("midrst_out_data", s_od, 0);
    chk("midrst_occ", s_occ, 0);
    chk("midrst_in_ready", s_ir, 1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'h201 + 32'(k), 1'b1, 1'b0);
    drain();
    exact_lat = 0;

    // Random traffic with random backpressure and rare flushes.
    do_reset(1'b0, 1'b0);
    n = 0;
    for (int t = 0; t < 20000 && n < 1000; t++) begin
      vi   = ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 1) != 0;
      fl   = ($urandom_range(0, 99) == 0);
      d    = $urandom;
      cyc(vi, d, ordy, fl);
      if (vi && s_ir) n++;
    end
    chk("random_accept_count", n, 1000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
